issue_commit_queue: RTL and testbench

- Parametrised in-order tracking queue between issue and commit. Successor to the fixed 4-entry, single-commit-port configuration.
- Allocates one entry per cycle and records out-of-order writeback completion.
- Retires up to NR_COMMIT_PORTS finished entries per cycle, strictly in program order.
- FPGA_EN selects a storage mode: no-reset payload array (LUTRAM-friendly) or fully reset storage.

---
 rtl/issue_commit_queue_pkg.sv | 23 ++
 rtl/issue_commit_queue_ram.sv | 49 ++++
 rtl/issue_commit_queue.sv | 107 ++++++++++
 tb/tb_issue_commit_queue.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/issue_commit_queue_pkg.sv
// Shared configuration for the issue/commit tracking queue.
//   NrScoreboardEntries : default queue depth
//   NrCommitPorts       : default number of commit ports
//   FpgaEn              : default storage mode (1 = no-reset payload array)
//   entry_state_t       : per-entry bookkeeping bits {valid, done}
//   calc_idw()          : entry index width for a given depth
package issue_commit_queue_pkg;

  localparam int unsigned NrScoreboardEntries = 4;
  localparam int unsigned NrCommitPorts       = 1;
  localparam bit          FpgaEn              = 1'b1;

  typedef struct packed {
    logic valid;
    logic done;
  } entry_state_t;

  // A one-bit index is kept even for degenerate depths so vectors stay legal.
  function automatic int unsigned calc_idw(input int unsigned nr_entries);
    return (nr_entries > 2) ? $clog2(nr_entries) : 1;
  endfunction

endpackage

// File: rtl/issue_commit_queue_ram.sv
// Payload storage for the issue/commit queue.
//   clk_i, rst_i : clock and synchronous active-high reset (reset-mode only)
//   we_i, waddr_i, wdata_i : single write port
//   raddr_i : NR_READ_PORTS packed read addresses, port 0 in the LSBs
//   rdata_o : NR_READ_PORTS asynchronous read data, port 0 in the LSBs
module issue_commit_queue_ram #(
  parameter int unsigned NR_ENTRIES    = 4,
  parameter int unsigned NR_READ_PORTS = 1,
  parameter int unsigned DATA_WIDTH    = 32,
  parameter bit          FPGA_EN       = 1'b1,
  parameter int unsigned IDW           = 2
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                we_i,
  input  logic [IDW-1:0]                      waddr_i,
  input  logic [DATA_WIDTH-1:0]               wdata_i,
  input  logic [NR_READ_PORTS*IDW-1:0]        raddr_i,
  output logic [NR_READ_PORTS*DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [NR_ENTRIES];

  if (FPGA_EN) begin : g_noreset
    // No reset keeps the array mappable onto distributed RAM.
    logic unused_rst;
    assign unused_rst = rst_i;

    always_ff @(posedge clk_i) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
    end
  end else begin : g_reset
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < NR_ENTRIES; i++) mem_q[i] <= '0;
      end else if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int unsigned i = 0; i < NR_READ_PORTS; i++) begin
      rdata_o[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr_i[i*IDW +: IDW]];
    end
  end

endmodule

// File: rtl/issue_commit_queue.sv
// In-order issue/commit tracking queue with out-of-order writeback.
//   clk_i, rst_i     : clock, synchronous active-high reset
//   flush_i          : discard all entries (wins over push/writeback/retire)
//   push_valid_i/push_ready_o/push_data_i/push_id_o : allocation interface
//   wb_valid_i/wb_id_i : mark an allocated entry finished
//   commit_valid_o/commit_data_o/commit_ack_i : NR_COMMIT_PORTS in-order retire ports
//   count_o          : number of occupied entries
module issue_commit_queue
  import issue_commit_queue_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = NrScoreboardEntries,
  parameter int unsigned NR_COMMIT_PORTS = NrCommitPorts,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter bit          FPGA_EN         = FpgaEn,
  parameter int unsigned IDW             = calc_idw(NR_ENTRIES)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  flush_i,
  input  logic                                  push_valid_i,
  output logic                                  push_ready_o,
  input  logic [DATA_WIDTH-1:0]                 push_data_i,
  output logic [IDW-1:0]                        push_id_o,
  input  logic                                  wb_valid_i,
  input  logic [IDW-1:0]                        wb_id_i,
  output logic [NR_COMMIT_PORTS-1:0]            commit_valid_o,
  output logic [NR_COMMIT_PORTS*DATA_WIDTH-1:0] commit_data_o,
  input  logic [NR_COMMIT_PORTS-1:0]            commit_ack_i,
  output logic [IDW:0]                          count_o
);

  entry_state_t st_q [NR_ENTRIES];
  logic [IDW-1:0] head_q, tail_q;
  logic [IDW:0]   count_q;

  logic                       push_fire;
  logic [NR_COMMIT_PORTS-1:0] ack_eff;
  logic [IDW:0]               n_retired;
  logic                       head_ok, ack_ok;
  logic [IDW-1:0]             commit_idx [NR_COMMIT_PORTS];
  logic [NR_COMMIT_PORTS*IDW-1:0] raddr;

  // Full is judged on the registered count only, so a same-cycle retire never admits a push.
  assign push_ready_o = (count_q != (IDW+1)'(NR_ENTRIES));
  assign push_fire    = push_valid_i & push_ready_o;
  assign push_id_o    = tail_q;
  assign count_o      = count_q;

  for (genvar g = 0; g < NR_COMMIT_PORTS; g++) begin : g_idx
    assign commit_idx[g]           = head_q + IDW'(g);
    assign raddr[g*IDW +: IDW]     = commit_idx[g];
  end

  // Port i is valid only if every lower port is; an ack counts only with all lower acks.
  always_comb begin
    commit_valid_o = '0;
    ack_eff        = '0;
    n_retired      = '0;
    head_ok        = 1'b1;
    ack_ok         = 1'b1;
    for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
      head_ok           = head_ok & st_q[commit_idx[i]].valid & st_q[commit_idx[i]].done;
      commit_valid_o[i] = head_ok;
      ack_ok            = ack_ok & head_ok & commit_ack_i[i];
      ack_eff[i]        = ack_ok;
      if (ack_ok) n_retired = n_retired + (IDW+1)'(1);
    end
  end

  // Writeback is applied before retire and push so that both override it on the same entry.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < NR_ENTRIES; i++) st_q[i] <= '0;
    end else begin
      if (wb_valid_i && st_q[wb_id_i].valid) st_q[wb_id_i].done <= 1'b1;
      for (int unsigned i = 0; i < NR_COMMIT_PORTS; i++) begin
        if (ack_eff[i]) st_q[commit_idx[i]] <= '0;
      end
      if (push_fire) begin
        st_q[tail_q] <= '{valid: 1'b1, done: 1'b0};
        tail_q       <= tail_q + IDW'(1);
      end
      head_q  <= head_q + n_retired[IDW-1:0];
      count_q <= count_q + (IDW+1)'(push_fire) - n_retired;
    end
  end

  issue_commit_queue_ram #(
    .NR_ENTRIES   (NR_ENTRIES),
    .NR_READ_PORTS(NR_COMMIT_PORTS),
    .DATA_WIDTH   (DATA_WIDTH),
    .FPGA_EN      (FPGA_EN),
    .IDW          (IDW)
  ) i_ram (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (push_fire & ~flush_i),
    .waddr_i(tail_q),
    .wdata_i(push_data_i),
    .raddr_i(raddr),
    .rdata_o(commit_data_o)
  );

endmodule

// File: tb/tb_issue_commit_queue.sv
module tb_issue_commit_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        push_valid;
  logic        push_ready;
  logic [31:0] push_data;
  logic [1:0]  push_id;
  logic        wb_valid;
  logic [1:0]  wb_id;
  logic [1:0]  commit_valid;
  logic [63:0] commit_data;
  logic [1:0]  commit_ack;
  logic [2:0]  count;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  issue_commit_queue #(
    .NR_ENTRIES     (4),
    .NR_COMMIT_PORTS(2),
    .DATA_WIDTH     (32),
    .FPGA_EN        (1'b0)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .flush_i       (flush),
    .push_valid_i  (push_valid),
    .push_ready_o  (push_ready),
    .push_data_i   (push_data),
    .push_id_o     (push_id),
    .wb_valid_i    (wb_valid),
    .wb_id_i       (wb_id),
    .commit_valid_o(commit_valid),
    .commit_data_o (commit_data),
    .commit_ack_i  (commit_ack),
    .count_o       (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Scoreboard monitor: every retire the bench causes must present the next expected payload.
  always @(negedge clk) begin
    if (!rst && !flush) begin
      bit e0, e1;
      e0 = commit_valid[0] & commit_ack[0];
      e1 = e0 & commit_valid[1] & commit_ack[1];
      if (e0) begin
        if (exp_q.size() == 0) chk("commit0_unexpected", {32'h0, commit_data[31:0]}, 64'hDEAD);
        else chk("commit0_data", {32'h0, commit_data[31:0]}, {32'h0, exp_q.pop_front()});
      end
      if (e1) begin
        if (exp_q.size() == 0) chk("commit1_unexpected", {32'h0, commit_data[63:32]}, 64'hDEAD);
        else chk("commit1_data", {32'h0, commit_data[63:32]}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; push_valid = 1'b0; push_data = '0;
    wb_valid = 1'b0; wb_id = '0; commit_ack = '0;
    tick(); tick();
    rst = 1'b0;
    sample();
    chk("rst_ready", push_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_cvalid", commit_valid, 0);
    chk("rst_cdata", commit_data, 0);
    chk("rst_id", push_id, 0);
    tick();

    // Fill to full
    for (int k = 0; k < 4; k++) begin
      push_valid = 1'b1; push_data = 32'hA0 + k;
      sample();
      chk("fill_id", push_id, k);
      chk("fill_ready", push_ready, 1);
      exp_q.push_back(push_data);
      tick();
    end
    push_valid = 1'b0; wb_valid = 1'b1; wb_id = 2'd0;
    sample();
    chk("full_count", count, 4);
    chk("full_ready", push_ready, 0);
    chk("wb_no_bypass", commit_valid, 2'b00);
    tick();
    // Push while full plus a retire in the same cycle: push must be dropped
    wb_valid = 1'b0; push_valid = 1'b1; push_data = 32'hA4; commit_ack = 2'b01;
    sample();
    chk("full_ack_ready", push_ready, 0);
    chk("full_ack_cvalid", commit_valid, 2'b01);
    tick();
    push_valid = 1'b0; commit_ack = 2'b00;
    sample();
    chk("after_full_count", count, 3);
    chk("after_full_ready", push_ready, 1);
    chk("after_full_cvalid", commit_valid, 2'b00);
    tick();
    for (int k = 1; k < 4; k++) begin
      wb_valid = 1'b1; wb_id = 2'(k);
      tick();
    end
    wb_valid = 1'b0; commit_ack = 2'b11;
    sample();
    chk("drain_cvalid2", commit_valid, 2'b11);
    tick();
    sample();
    chk("drain_count1", count, 1);
    chk("drain_cvalid1", commit_valid, 2'b01);
    tick();
    commit_ack = 2'b00;
    sample();
    chk("drain_empty", count, 0);
    tick();

    // Out-of-order writeback, dual commit
    for (int k = 0; k < 3; k++) begin
      push_valid = 1'b1; push_data = 32'hB0 + k;
      sample();
      chk("ooo_id", push_id, k);
      exp_q.push_back(push_data);
      tick();
    end
    push_valid = 1'b0; wb_valid = 1'b1; wb_id = 2'd2;
    tick();
    wb_id = 2'd1;
    sample();
    chk("ooo_cv_after_wb2", commit_valid, 2'b00);
    tick();
    wb_id = 2'd0;
    sample();
    chk("ooo_cv_after_wb1", commit_valid, 2'b00);
    tick();
    wb_valid = 1'b0; commit_ack = 2'b11;
    sample();
    chk("ooo_cv_both", commit_valid, 2'b11);
    chk("ooo_data0", commit_data[31:0], 32'hB0);
    chk("ooo_data1", commit_data[63:32], 32'hB1);
    tick();
    commit_ack = 2'b00; push_valid = 1'b1; push_data = 32'hB3;
    sample();
    chk("ooo_count1", count, 1);
    chk("ooo_head2_cv", commit_valid, 2'b01);
    chk("ooo_head2_data", commit_data[31:0], 32'hB2);
    chk("ooo_push_id3", push_id, 3);
    exp_q.push_back(push_data);
    tick();
    push_valid = 1'b0; wb_valid = 1'b1; wb_id = 2'd3;
    tick();
    wb_valid = 1'b0; commit_ack = 2'b10;
    sample();
    chk("ack10_cv", commit_valid, 2'b11);
    tick();
    commit_ack = 2'b01;
    sample();
    chk("ack10_count", count, 2);
    chk("ack10_cv_kept", commit_valid, 2'b11);
    tick();
    sample();
    chk("ack01_count", count, 1);
    chk("ack01_cv", commit_valid, 2'b01);
    chk("ack01_data", commit_data[31:0], 32'hB3);
    tick();
    commit_ack = 2'b00;
    sample();
    chk("ack01_empty", count, 0);
    tick();

    // Wrap-around streaming: one push, one writeback, one retire per cycle
    for (int t = 0; t < 8; t++) begin
      push_valid = (t < 6);
      push_data  = 32'hC0 + t;
      wb_valid   = (t >= 1 && t <= 6);
      wb_id      = 2'(t - 1);
      commit_ack = (t >= 2) ? 2'b01 : 2'b00;
      sample();
      if (t < 6) begin
        chk("wrap_id", push_id, t % 4);
        chk("wrap_ready", push_ready, 1);
        exp_q.push_back(push_data);
      end
      if (t >= 2) chk("wrap_no_stall", commit_valid[0], 1);
      tick();
    end
    push_valid = 1'b0; wb_valid = 1'b0; commit_ack = 2'b00;
    sample();
    chk("wrap_empty", count, 0);
    tick();

    // Flush colliding with push, writeback and retire
    for (int k = 0; k < 2; k++) begin
      push_valid = 1'b1; push_data = 32'hE0 + k;
      sample();
      chk("pre_flush_id", push_id, 2 + k);
      exp_q.push_back(push_data);
      tick();
    end
    push_valid = 1'b0; wb_valid = 1'b1; wb_id = 2'd2;
    tick();
    flush = 1'b1; push_valid = 1'b1; push_data = 32'hFF; wb_id = 2'd3; commit_ack = 2'b01;
    sample();
    chk("pre_flush_cv", commit_valid, 2'b01);
    tick();
    exp_q.delete();
    flush = 1'b0; push_valid = 1'b0; wb_valid = 1'b0; commit_ack = 2'b00;
    sample();
    chk("flush_count", count, 0);
    chk("flush_cv", commit_valid, 2'b00);
    chk("flush_id", push_id, 0);
    chk("flush_ready", push_ready, 1);
    tick();
    push_valid = 1'b1; push_data = 32'h60;
    sample();
    chk("post_flush_id", push_id, 0);
    exp_q.push_back(push_data);
    tick();
    push_valid = 1'b0; wb_valid = 1'b1; wb_id = 2'd0;
    sample();
    chk("post_flush_count", count, 1);
    tick();
    wb_valid = 1'b0; commit_ack = 2'b01;
    sample();
    chk("post_flush_cv", commit_valid, 2'b01);
    tick();
    commit_ack = 2'b00;
    sample();
    chk("final_count", count, 0);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
